// File: rtl/uart_dev_input.sv
// 8N1 UART receiver that keeps 5-bit device codes (0x00-0x1F) and serves them
// through a small first-word-fall-through FIFO as a valid/ready stream.
module uart_dev_input #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               uart_rx,
  input  logic               dev_input_rdy,
  output logic               dev_input_val,
  output logic [4:0]         dev_input_data,
  input  logic               clr_err,
  output logic               err_frame,
  output logic               err_range,
  output logic               err_overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam int                DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  DEPTH_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer; both flops idle high so reset never looks like a start.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic             byte_done;
  logic             frame_bad;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + CNT_ONE;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;

    unique case (state)
      S_IDLE: begin
        baud_cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        // Mid-bit recheck rejects short low glitches on an idle line.
        if (baud_cnt == HALF_CNT) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_cnt == LAST_CNT) begin
          baud_cnt_n = '0;
          shift_n    = {rx_s, shift[7:1]};
          if (bit_cnt == 3'd7) state_n = S_STOP;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_cnt == LAST_CNT) begin
          baud_cnt_n = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_n   = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_n   = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A break holds the line low; wait for it to return high before
        // hunting for the next start bit.
        baud_cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        baud_cnt_n = '0;
        state_n    = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Code filter and FIFO control
  // ---------------------------------------------------------------------------
  logic               code_ok;
  logic               range_bad;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               overflow_evt;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [4:0]         mem [DEPTH];

  assign code_ok      = byte_done && (shift[7:5] == 3'b000);
  assign range_bad    = byte_done && (shift[7:5] != 3'b000);
  assign fifo_full    = (fifo_level == DEPTH_LVL);
  assign dev_input_val = (fifo_level != '0);
  assign pop          = dev_input_val && dev_input_rdy;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push         = code_ok && (!fifo_full || pop);
  assign overflow_evt = code_ok && fifo_full && !pop;

  // NOTE: storage is deliberately left out of reset; occupancy is tracked by
  // fifo_level and the output is gated, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift[4:0];
  end

  assign dev_input_data = dev_input_val ? mem[rd_ptr] : 5'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; a new event outranks a clear on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_frame    <= 1'b0;
      err_range    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (frame_bad)         err_frame <= 1'b1;
      else if (clr_err)      err_frame <= 1'b0;

      if (range_bad)         err_range <= 1'b1;
      else if (clr_err)      err_range <= 1'b0;

      if (overflow_evt)      err_overflow <= 1'b1;
      else if (clr_err)      err_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_dev_input.sv
// Directed bench for uart_dev_input at 8 clocks per bit and a 4-deep FIFO;
// expected values are hand-derived from the frame timing.
module tb_uart_dev_input;

  localparam int CPB = 8;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          uart_rx;
  logic          dev_input_rdy;
  logic          dev_input_val;
  logic [4:0]    dev_input_data;
  logic          clr_err;
  logic          err_frame;
  logic          err_range;
  logic          err_overflow;
  logic [AW:0]   fifo_level;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  uart_dev_input #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .uart_rx        (uart_rx),
    .dev_input_rdy  (dev_input_rdy),
    .dev_input_val  (dev_input_val),
    .dev_input_data (dev_input_data),
    .clr_err        (clr_err),
    .err_frame      (err_frame),
    .err_range      (err_range),
    .err_overflow   (err_overflow),
    .fifo_level     (fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_errs(input string tag, input logic f, input logic r, input logic o);
    check({tag, ".err_frame"},    err_frame,    f);
    check({tag, ".err_range"},    err_range,    r);
    check({tag, ".err_overflow"}, err_overflow, o);
  endtask

  // Start bit, 8 data bits LSB first, then the stop level held stop_cycles clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cycles);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(stop_cycles);
  endtask

  initial begin
    resetn        = 1'b0;
    uart_rx       = 1'b1;
    dev_input_rdy = 1'b0;
    clr_err       = 1'b0;
    tick(3);

    // Reset state
    check("rst.val",   dev_input_val,  1'b0);
    check("rst.data",  dev_input_data, 5'h00);
    check("rst.level", fifo_level,     3'd0);
    check_errs("rst", 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick(4);

    // Single code with the consumer ready: val high for exactly the cycle
    // after the stop-sample edge.
    dev_input_rdy = 1'b1;
    send_frame(8'h15, 1'b1, CPB - 1);
    check("t1.val_before", dev_input_val, 1'b0);
    tick(1);
    check("t1.val",   dev_input_val,  1'b1);
    check("t1.data",  dev_input_data, 5'h15);
    check("t1.level", fifo_level,     3'd1);
    tick(1);
    check("t1.val_after",   dev_input_val, 1'b0);
    check("t1.level_after", fifo_level,    3'd0);
    check_errs("t1", 1'b0, 1'b0, 1'b0);

    // Five codes into a 4-deep FIFO with the consumer stalled.
    dev_input_rdy = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, CPB);
    check("t2.level", fifo_level, 3'd4);
    check("t2.ovf",   err_overflow, 1'b1);
    check("t2.val",   dev_input_val, 1'b1);
    check("t2.head0", dev_input_data, 5'h01);
    dev_input_rdy = 1'b1;
    tick(1);
    check("t2.head1", dev_input_data, 5'h02);
    tick(1);
    check("t2.head2", dev_input_data, 5'h03);
    tick(1);
    check("t2.head3", dev_input_data, 5'h04);
    check("t2.level1", fifo_level, 3'd1);
    tick(1);
    check("t2.drained_val",   dev_input_val, 1'b0);
    check("t2.drained_level", fifo_level,    3'd0);
    dev_input_rdy = 1'b0;

    // Out-of-range byte, error clear, then the largest legal code.
    send_frame(8'h41, 1'b1, CPB);
    check("t3.val",   dev_input_val, 1'b0);
    check("t3.level", fifo_level,    3'd0);
    check("t3.range", err_range,     1'b1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check_errs("t3.clr", 1'b0, 1'b0, 1'b0);
    send_frame(8'h1F, 1'b1, CPB);
    check("t3.val_1f",  dev_input_val,  1'b1);
    check("t3.data_1f", dev_input_data, 5'h1F);
    dev_input_rdy = 1'b1;
    tick(1);
    dev_input_rdy = 1'b0;
    check("t3.level_after", fifo_level, 3'd0);

    // Framing error followed by a break; the next clean byte must arrive intact.
    send_frame(8'h0A, 1'b0, 3 * CPB);
    check("t4.frame",   err_frame,  1'b1);
    check("t4.level",   fifo_level, 3'd0);
    uart_rx = 1'b1;
    tick(CPB);
    send_frame(8'h03, 1'b1, CPB);
    check("t4.level_03", fifo_level,     3'd1);
    check("t4.data_03",  dev_input_data, 5'h03);
    check_errs("t4", 1'b1, 1'b0, 1'b0);
    dev_input_rdy = 1'b1;
    clr_err       = 1'b1;
    tick(1);
    dev_input_rdy = 1'b0;
    clr_err       = 1'b0;
    check("t4.frame_clr", err_frame, 1'b0);

    // Two-clock low glitch on the idle line.
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(2 * CPB);
    check("t5.val",   dev_input_val, 1'b0);
    check("t5.level", fifo_level,    3'd0);
    check_errs("t5", 1'b0, 1'b0, 1'b0);

    // Full FIFO: push and pop on the same edge.
    for (int v = 8'h11; v <= 8'h14; v++) send_frame(8'(v), 1'b1, CPB);
    check("t6.full", fifo_level, 3'd4);
    send_frame(8'h15, 1'b1, CPB - 1);
    dev_input_rdy = 1'b1;
    tick(1);
    check("t6.level_same", fifo_level,     3'd4);
    check("t6.ovf",        err_overflow,   1'b0);
    check("t6.head12",     dev_input_data, 5'h12);
    tick(1);
    check("t6.head13", dev_input_data, 5'h13);
    tick(1);
    check("t6.head14", dev_input_data, 5'h14);
    tick(1);
    dev_input_rdy = 1'b0;
    check("t6.head15", dev_input_data, 5'h15);
    check("t6.level1", fifo_level,     3'd1);

    // Reset in the middle of the data bits of the next byte.
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(3);
    resetn = 1'b0;
    #1;
    check("t7.val",   dev_input_val,  1'b0);
    check("t7.level", fifo_level,     3'd0);
    check("t7.data",  dev_input_data, 5'h00);
    uart_rx = 1'b1;
    tick(2);
    resetn = 1'b1;
    tick(4);
    send_frame(8'h07, 1'b1, CPB);
    check("t7.level_07", fifo_level,     3'd1);
    check("t7.data_07",  dev_input_data, 5'h07);
    check_errs("t7", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
